// File: rtl/stopwatch_lap_core.sv
// Stopwatch core: BCD up/down timer with a tenth-second prescaler,
// a run/pause/done FSM and a small lap buffer with display readback.
module stopwatch_lap_core #(
  parameter int TICK_DIV   = 10_000_000,
  parameter int MIN_DIGITS = 1,
  parameter int LAP_DEPTH  = 4,
  localparam int W   = 4 * (MIN_DIGITS + 3),
  localparam int LCW = $clog2(LAP_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           stop,
  input  logic           clear,
  input  logic           lap,
  input  logic           count_down,
  input  logic [W-1:0]   preset_bcd,
  input  logic           view_lap,
  input  logic           lap_rd,
  output logic [W-1:0]   time_bcd,
  output logic [W-1:0]   disp_bcd,
  output logic           running,
  output logic           done,
  output logic [LCW-1:0] lap_count,
  output logic           lap_full
);

  localparam int PW  = $clog2(TICK_DIV);
  localparam int RPW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t         state;
  logic [PW-1:0]  presc;
  logic           mode;
  logic           tick;
  logic           lap_act;
  logic           lap_ok;
  logic [W-1:0]   nxt_time;
  logic [RPW-1:0] rd_ptr;
  logic [LCW-1:0] rd_nxt;
  logic [W-1:0]   lap_mem [LAP_DEPTH];

  // One BCD step up or down; digit 2 is tens-of-seconds (0..5).
  function automatic logic [W-1:0] bcd_step(
    input logic [W-1:0] t,
    input logic         dn
  );
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    logic [3:0]   mx;
    r = t;
    c = 1'b1;
    for (int i = 0; i < W / 4; i++) begin
      d  = t[4*i +: 4];
      mx = (i == 2) ? 4'd5 : 4'd9;
      if (c) begin
        if (dn) begin
          if (d == 4'd0) d = mx;
          else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == mx) d = 4'd0;
          else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  assign nxt_time = bcd_step(time_bcd, mode);
  assign tick     = (state == RUN) && (presc == PW'(TICK_DIV - 1));
  assign running  = (state == RUN);
  assign done     = (state == DONE);
  assign lap_act  = lap && !clear && (state == RUN || state == PAUSE);
  assign lap_ok   = lap_act && (lap_count != LCW'(LAP_DEPTH));
  assign rd_nxt   = LCW'(rd_ptr) + LCW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      presc    <= '0;
      mode     <= 1'b0;
      time_bcd <= '0;
    end else if (clear) begin
      state    <= IDLE;
      presc    <= '0;
      time_bcd <= count_down ? preset_bcd : '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            mode  <= count_down;
            presc <= '0;
            state <= (count_down && time_bcd == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (stop) state <= PAUSE;
          if (tick) begin
            time_bcd <= nxt_time;
            // reaching zero wins over a coincident stop
            if (mode && nxt_time == '0) state <= DONE;
          end
        end
        PAUSE: begin
          if (start && !stop) state <= RUN;
        end
        DONE: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_count <= '0;
      lap_full  <= 1'b0;
      rd_ptr    <= '0;
      disp_bcd  <= '0;
    end else begin
      if (!view_lap)            disp_bcd <= time_bcd;
      else if (lap_count != 0)  disp_bcd <= lap_mem[rd_ptr];
      else                      disp_bcd <= '0;
      if (clear) begin
        lap_count <= '0;
        lap_full  <= 1'b0;
        rd_ptr    <= '0;
      end else begin
        if (lap_ok) lap_count <= lap_count + LCW'(1);
        if (lap_act && !lap_ok) lap_full <= 1'b1;
        if (lap_rd && lap_count != 0)
          rd_ptr <= (rd_nxt == lap_count) ? '0 : RPW'(rd_nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (lap_ok) lap_mem[RPW'(lap_count)] <= time_bcd;
  end

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench for stopwatch_lap_core: vector table of pulses and
// expected outputs, plus a hand-written async reset sequence.
module tb_stopwatch_lap_core;

  logic        clk;
  logic        reset;
  logic        start, stop, clear, lap;
  logic        count_down;
  logic [15:0] preset_bcd;
  logic        view_lap, lap_rd;
  logic [15:0] time_bcd, disp_bcd;
  logic        running, done;
  logic [1:0]  lap_count;
  logic        lap_full;

  int tests = 0;
  int fails = 0;

  stopwatch_lap_core #(
    .TICK_DIV(4),
    .MIN_DIGITS(1),
    .LAP_DEPTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .clear(clear),
    .lap(lap),
    .count_down(count_down),
    .preset_bcd(preset_bcd),
    .view_lap(view_lap),
    .lap_rd(lap_rd),
    .time_bcd(time_bcd),
    .disp_bcd(disp_bcd),
    .running(running),
    .done(done),
    .lap_count(lap_count),
    .lap_full(lap_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st, sp, cl, lp, cd;
    logic [15:0] pre;
    logic        vl, rd;
    int          n;
    logic [15:0] t;
    logic        dc;
    logic [15:0] d;
    logic        run, dn;
    logic [1:0]  lc;
    logic        full;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic st, logic sp, logic cl, logic lp, logic cd,
    logic [15:0] pre, logic vl, logic rd, int n,
    logic [15:0] t, logic dc, logic [15:0] d,
    logic run, logic dn, logic [1:0] lc, logic full
  );
    vec_t v;
    v.st = st; v.sp = sp; v.cl = cl; v.lp = lp; v.cd = cd;
    v.pre = pre; v.vl = vl; v.rd = rd; v.n = n;
    v.t = t; v.dc = dc; v.d = d;
    v.run = run; v.dn = dn; v.lc = lc; v.full = full;
    return v;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_vec(vec_t v, string tag);
    chk({tag, " time"}, time_bcd, v.t);
    if (v.dc) chk({tag, " disp"}, disp_bcd, v.d);
    chk({tag, " running"}, 16'(running), 16'(v.run));
    chk({tag, " done"}, 16'(done), 16'(v.dn));
    chk({tag, " lap_count"}, 16'(lap_count), 16'(v.lc));
    chk({tag, " lap_full"}, 16'(lap_full), 16'(v.full));
  endtask

  // Called at a negedge: pulses cover one posedge, then n more edges.
  task automatic apply(vec_t v, string tag);
    start = v.st; stop = v.sp; clear = v.cl; lap = v.lp;
    count_down = v.cd; preset_bcd = v.pre;
    view_lap = v.vl; lap_rd = v.rd;
    @(negedge clk);
    start = 0; stop = 0; clear = 0; lap = 0; lap_rd = 0;
    repeat (v.n) @(negedge clk);
    check_vec(v, tag);
  endtask

  initial begin
    reset = 0;
    start = 0; stop = 0; clear = 0; lap = 0; lap_rd = 0;
    count_down = 0; preset_bcd = '0; view_lap = 0;

    //         st sp cl lp cd pre     vl rd  n  time    dc disp    r  d  lc fl
    tbl.push_back(mk(0,0,1,0,0,16'h0000,0,0, 0,16'h0000,1,16'h0000,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,16'h0000,0,0,40,16'h0010,1,16'h0009,1,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,16'h0000,0,0, 0,16'h0000,0,16'h0000,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,16'h0000,0,0,12,16'h0003,0,16'h0000,1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,16'h0000,0,0, 0,16'h0003,0,16'h0000,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,16'h0000,0,0,14,16'h0007,0,16'h0000,1,0,1,0));
    tbl.push_back(mk(0,0,0,1,0,16'h0000,0,0, 0,16'h0007,0,16'h0000,1,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,16'h0000,0,0,14,16'h0011,0,16'h0000,1,0,2,0));
    tbl.push_back(mk(0,0,0,1,0,16'h0000,0,0, 0,16'h0011,0,16'h0000,1,0,2,1));
    tbl.push_back(mk(0,0,0,0,0,16'h0000,1,0, 0,16'h0011,1,16'h0003,1,0,2,1));
    tbl.push_back(mk(0,0,0,0,0,16'h0000,1,1, 1,16'h0012,1,16'h0007,1,0,2,1));
    tbl.push_back(mk(0,0,0,0,0,16'h0000,1,1, 1,16'h0012,1,16'h0003,1,0,2,1));
    tbl.push_back(mk(0,1,0,0,0,16'h0000,0,0, 0,16'h0012,0,16'h0000,0,0,2,1));
    tbl.push_back(mk(1,1,0,0,0,16'h0000,0,0, 0,16'h0012,0,16'h0000,0,0,2,1));
    tbl.push_back(mk(1,0,0,0,0,16'h0000,0,0, 1,16'h0013,0,16'h0000,1,0,2,1));
    tbl.push_back(mk(0,0,1,1,0,16'h0000,0,0, 0,16'h0000,0,16'h0000,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,16'h0002,0,0, 0,16'h0002,0,16'h0000,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,16'h0002,0,0, 7,16'h0001,0,16'h0000,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,16'h0002,0,0, 0,16'h0000,0,16'h0000,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,16'h0005,0,0, 3,16'h0000,0,16'h0000,0,1,0,0));
    tbl.push_back(mk(0,0,1,0,1,16'h0000,0,0, 0,16'h0000,0,16'h0000,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,16'h0000,0,0, 0,16'h0000,0,16'h0000,0,1,0,0));
    tbl.push_back(mk(0,0,1,0,1,16'h9599,0,0, 0,16'h9599,0,16'h0000,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,16'h9599,0,0, 4,16'h0000,0,16'h0000,1,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,16'h1000,0,0, 0,16'h1000,0,16'h0000,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,16'h1000,0,0, 4,16'h0599,0,16'h0000,1,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,16'h0000,0,0, 0,16'h0000,0,16'h0000,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,16'h0000,0,0, 0,16'h0000,0,16'h0000,0,0,0,0));

    #3;
    chk("reset time", time_bcd, 16'h0000);
    chk("reset disp", disp_bcd, 16'h0000);
    chk("reset flags", {12'h0, running, done, lap_full, 1'b0}, 16'h0000);
    chk("reset lap_count", 16'(lap_count), 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // Async reset in the middle of a run.
    apply(mk(1,0,0,0,0,16'h0000,0,0,6,16'h0001,1,16'h0001,1,0,0,0),
          "pre_rst");
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("async time", time_bcd, 16'h0000);
    chk("async disp", disp_bcd, 16'h0000);
    chk("async running", 16'(running), 16'h0000);
    start = 1;
    @(negedge clk);
    reset = 1;
    start = 0;
    repeat (6) @(negedge clk);
    chk("post_rst time", time_bcd, 16'h0000);
    chk("post_rst running", 16'(running), 16'h0000);
    apply(mk(1,0,0,0,0,16'h0000,0,0,4,16'h0001,0,16'h0000,1,0,0,0),
          "resume");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
